// File: rtl/sweep_monitor.sv
// Sweep monitor: watches a counter for runs of non-zero values that end in 0,
// and queues one {peak, len, shrink, mono_err} record per run in a FWFT FIFO.
module sweep_monitor #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         count,
  input  logic                     clr_err,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [WIDTH-1:0]         rec_peak,
  output logic [LEN_W-1:0]         rec_len,
  output logic                     rec_shrink,
  output logic                     rec_mono_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int REC_W = WIDTH + LEN_W + 2;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state, state_nx;
  logic               sweep_end;
  logic [WIDTH-1:0]   prev, peak, last_peak;
  logic [LEN_W-1:0]   len;
  logic               mono, have_last, shrink;
  logic [REC_W-1:0]   rec_new;
  logic [REC_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wptr, rptr;
  logic               pop, push, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    sweep_end = 1'b0;
    case (state)
      IDLE:  if (count != '0) state_nx = SWEEP;
      SWEEP: if (count == '0) begin
        state_nx  = IDLE;
        sweep_end = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Accumulators; the record built at sweep end uses only pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      peak      <= '0;
      len       <= '0;
      mono      <= 1'b0;
      last_peak <= '0;
      have_last <= 1'b0;
    end else begin
      prev <= count;
      if (state == IDLE && count != '0) begin
        peak <= count;
        len  <= LEN_W'(1);
        mono <= (count != WIDTH'(1));
      end else if (state == SWEEP && count != '0) begin
        if (!(&len)) len <= len + LEN_W'(1);
        if (count > peak) peak <= count;
        if ({1'b0, count} != ({1'b0, prev} + (WIDTH+1)'(1))) mono <= 1'b1;
      end
      if (sweep_end) begin
        last_peak <= peak;
        have_last <= 1'b1;
      end
    end
  end

  assign shrink  = have_last & (peak < last_peak);
  assign rec_new = {peak, len, shrink, mono};

  assign rec_valid = (level != '0);
  assign pop       = rec_valid & rec_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = sweep_end & ((level < (PTR_W+1)'(DEPTH)) | pop);
  assign drop      = sweep_end & ~push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= rec_new;
        wptr      <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + (PTR_W+1)'(1);
        2'b01:   level <= level - (PTR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign {rec_peak, rec_len, rec_shrink, rec_mono_err} = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          drop_err <= 1'b0;
    else if (drop)    drop_err <= 1'b1;
    else if (clr_err) drop_err <= 1'b0;
  end

endmodule

// File: tb/tb_sweep_monitor.sv
// Testbench for sweep_monitor: directed and random sweeps against a queue-based
// reference model of sweep records and FIFO occupancy.
module tb_sweep_monitor;
  localparam int WIDTH = 4;
  localparam int LEN_W = 6;
  localparam int DEPTH = 4;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [WIDTH-1:0]       count;
  logic                   clr_err;
  logic                   rec_valid;
  logic                   rec_ready;
  logic [WIDTH-1:0]       rec_peak;
  logic [LEN_W-1:0]       rec_len;
  logic                   rec_shrink;
  logic                   rec_mono_err;
  logic [$clog2(DEPTH):0] level;
  logic                   drop_err;

  sweep_monitor #(.WIDTH(WIDTH), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .count(count), .clr_err(clr_err),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_peak(rec_peak),
    .rec_len(rec_len), .rec_shrink(rec_shrink), .rec_mono_err(rec_mono_err),
    .level(level), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {int peak; int len; bit shrink; bit mono;} rec_t;

  rec_t q[$];
  int   cur[$];
  int   m_last_peak;
  bit   m_have_last;
  bit   m_drop;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cur.delete();
    m_last_peak = 0;
    m_have_last = 0;
    m_drop      = 0;
  endtask

  // One sample of the monitored counter seen as a whole: a sweep is the list
  // of non-zero samples, summarised when the 0 arrives.
  task automatic model_step(input int c, input bit r, input bit cl);
    bit   popm, dropm, have_new;
    rec_t nr;
    popm     = (q.size() != 0) && r;
    have_new = 0;
    dropm    = 0;
    if (c != 0) cur.push_back(c);
    else if (cur.size() != 0) begin
      nr.peak = 0;
      nr.mono = 0;
      foreach (cur[i]) begin
        if (cur[i] > nr.peak) nr.peak = cur[i];
        if (cur[i] != ((i == 0) ? 1 : cur[i-1] + 1)) nr.mono = 1;
      end
      nr.len    = (cur.size() > LEN_MAX) ? LEN_MAX : cur.size();
      nr.shrink = m_have_last && (nr.peak < m_last_peak);
      have_new  = 1;
      cur.delete();
    end
    if (popm) void'(q.pop_front());
    if (have_new) begin
      if (q.size() < DEPTH) q.push_back(nr);
      else dropm = 1;
      m_last_peak = nr.peak;
      m_have_last = 1;
    end
    if (dropm)   m_drop = 1;
    else if (cl) m_drop = 0;
  endtask

  task automatic compare_all();
    chk("valid", rec_valid, q.size() != 0);
    chk("level", level, q.size());
    chk("drop_err", drop_err, m_drop);
    if (q.size() != 0) begin
      chk("peak", rec_peak, q[0].peak);
      chk("len", rec_len, q[0].len);
      chk("shrink", rec_shrink, q[0].shrink);
      chk("mono_err", rec_mono_err, q[0].mono);
    end
  endtask

  // Called at a falling edge: drive, take the rising edge, check at the next fall.
  task automatic cyc(input int c, input bit r, input bit cl);
    count     = WIDTH'(c);
    rec_ready = r;
    clr_err   = cl;
    @(posedge clk);
    model_step(c, r, cl);
    @(negedge clk);
    compare_all();
  endtask

  task automatic sweep_to(input int pk, input bit r, input bit r_end);
    for (int v = 1; v <= pk; v++) cyc(v, r, 0);
    cyc(0, r_end, 0);
  endtask

  initial begin
    int k, pk;
    rst = 1'b1; count = '0; clr_err = 1'b0; rec_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", rec_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_peak", rec_peak, 0);
    rst = 1'b0;

    repeat (20) cyc(0, 1'($urandom_range(0, 1)), 0);

    sweep_to(15, 1, 1);
    chk("single_peak", rec_peak, 15);
    chk("single_len", rec_len, 15);
    cyc(0, 1, 0);
    chk("single_level", level, 0);

    sweep_to(15, 0, 0);
    sweep_to(14, 0, 0);
    sweep_to(13, 0, 0);
    chk("shrink_level", level, 3);
    repeat (3) cyc(0, 1, 0);
    sweep_to(13, 1, 1);
    chk("equal_no_shrink", rec_shrink, 0);
    cyc(0, 1, 0);

    for (int p = 9; p >= 5; p--) sweep_to(p, 0, 0);
    chk("ovf_level", level, 4);
    chk("ovf_drop", drop_err, 1);
    cyc(0, 0, 1);
    chk("clr_drop", drop_err, 0);
    repeat (4) cyc(0, 1, 0);

    sweep_to(3, 0, 0); sweep_to(2, 0, 0); sweep_to(3, 0, 0); sweep_to(2, 0, 0);
    sweep_to(4, 0, 1);
    chk("full_pp_level", level, 4);
    chk("full_pp_drop", drop_err, 0);
    repeat (4) cyc(0, 1, 0);

    cyc(1, 1, 0); cyc(2, 1, 0); cyc(5, 1, 0); cyc(6, 1, 0); cyc(0, 1, 0);
    chk("mono_peak", rec_peak, 6);
    chk("mono_len", rec_len, 4);
    chk("mono_err", rec_mono_err, 1);
    cyc(0, 1, 0);

    repeat (70) cyc(5, 1, 0);
    cyc(0, 1, 0);
    chk("len_sat", rec_len, LEN_MAX);
    cyc(0, 1, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        pk = $urandom_range(1, 15);
        sweep_to(pk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        k = $urandom_range(1, 12);
        for (int j = 0; j < k; j++)
          cyc(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15),
              1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      end
    end

    sweep_to(4, 0, 0);
    cyc(1, 0, 0); cyc(2, 0, 0); cyc(3, 0, 0);
    #2 rst = 1'b1;
    count = '0;
    #1;
    chk("async_valid", rec_valid, 0);
    chk("async_level", level, 0);
    chk("async_drop", drop_err, 0);
    chk("async_peak", rec_peak, 0);
    chk("async_len", rec_len, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) cyc(0, 1, 0);
    chk("no_rec_after_rst", rec_valid, 0);
    sweep_to(2, 1, 1);
    chk("post_rst_shrink", rec_shrink, 0);
    cyc(0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
